// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: core index, port select and
// the modulo-NCORE pointer increment.
package dpram_arb_pkg;

   // Sized for the largest supported cluster so every instance shares one index type.
   localparam int unsigned MaxCore = 8;
   localparam int unsigned IdxW    = $clog2(MaxCore);

   typedef logic [IdxW-1:0] core_idx_t;

   typedef enum logic [1:0] {PORT_NONE, PORT_A, PORT_B} port_sel_t;

   function automatic core_idx_t idx_inc(input core_idx_t idx, input int unsigned n);
      int unsigned nxt;
      nxt = 32'(idx) + 32'd1;
      return (nxt >= n) ? '0 : core_idx_t'(nxt);
   endfunction

endpackage

// File: rtl/rr_dual_pick.sv
// Combinational round-robin picker that finds up to two winners per cycle and
// skips a second writer that targets the same address as the port-A writer.
module rr_dual_pick
   import dpram_arb_pkg::*;
#(
   parameter int unsigned NCORE = 2,
   parameter int unsigned AW    = 8
) (
   input  logic                en_i,
   input  core_idx_t           ptr_i,
   input  logic [NCORE-1:0]    req_i,
   input  logic [NCORE-1:0]    we_i,
   input  logic [NCORE*AW-1:0] addr_i,
   output core_idx_t           idx_a_o,
   output logic                vld_a_o,
   output core_idx_t           idx_b_o,
   output logic                vld_b_o,
   output logic                conflict_o
);

   int unsigned   pos;
   logic          a_we;
   logic [AW-1:0] a_addr;

   always_comb begin
      idx_a_o    = '0;
      vld_a_o    = 1'b0;
      idx_b_o    = '0;
      vld_b_o    = 1'b0;
      conflict_o = 1'b0;
      pos        = 0;
      a_we       = 1'b0;
      a_addr     = '0;
      for (int k = 0; k < NCORE; k++) begin
         pos = (32'(ptr_i) + 32'(k)) % NCORE;
         for (int j = 0; j < NCORE; j++) begin
            if (en_i && pos == 32'(j) && req_i[j]) begin
               if (!vld_a_o) begin
                  vld_a_o = 1'b1;
                  idx_a_o = core_idx_t'(j);
                  a_we    = we_i[j];
                  a_addr  = addr_i[j*AW +: AW];
               end else if (!vld_b_o) begin
                  // Same-address write pair: the later core loses and retries.
                  if (a_we && we_i[j] && a_addr == addr_i[j*AW +: AW]) begin
                     conflict_o = 1'b1;
                  end else begin
                     vld_b_o = 1'b1;
                     idx_b_o = core_idx_t'(j);
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/dpram_port_arb.sv
// Front end that shares one true dual-port RAM among NCORE cores: two grants
// per cycle, read return tagging, mixed-port write forwarding, conflict count.
module dpram_port_arb
   import dpram_arb_pkg::*;
#(
   parameter int unsigned NCORE = 2,
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 16,
   parameter int unsigned CNTW  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCORE-1:0]    req,
   input  logic [NCORE-1:0]    we,
   input  logic [NCORE*AW-1:0] addr,
   input  logic [NCORE*DW-1:0] wdata,
   output logic [NCORE-1:0]    gnt,
   output logic [NCORE-1:0]    rvalid,
   output logic [NCORE*DW-1:0] rdata,
   output logic [AW-1:0]       ram_addr_a,
   output logic [AW-1:0]       ram_addr_b,
   output logic [DW-1:0]       ram_data_a,
   output logic [DW-1:0]       ram_data_b,
   output logic                ram_we_a,
   output logic                ram_we_b,
   input  logic [DW-1:0]       ram_q_a,
   input  logic [DW-1:0]       ram_q_b,
   output logic [CNTW-1:0]     conflict_cnt
);

   core_idx_t       rr_ptr_q, rr_ptr_d;
   core_idx_t       idx_a, idx_b;
   logic            vld_a, vld_b, conflict;
   port_sel_t       core_port [NCORE];

   logic            rd_a_q, rd_a_d, rd_b_q, rd_b_d;
   core_idx_t       own_a_q, own_b_q;
   logic            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [DW-1:0]   fwd_data_a_q, fwd_data_b_q;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   hold_q [NCORE];
   logic [DW-1:0]   rdata_lane [NCORE];

   // Holding the picker disabled in reset keeps grants and RAM writes low.
   rr_dual_pick #(
      .NCORE (NCORE),
      .AW    (AW)
   ) u_pick (
      .en_i       (rst),
      .ptr_i      (rr_ptr_q),
      .req_i      (req),
      .we_i       (we),
      .addr_i     (addr),
      .idx_a_o    (idx_a),
      .vld_a_o    (vld_a),
      .idx_b_o    (idx_b),
      .vld_b_o    (vld_b),
      .conflict_o (conflict)
   );

   always_comb begin
      ram_addr_a = '0;
      ram_data_a = '0;
      ram_we_a   = 1'b0;
      ram_addr_b = '0;
      ram_data_b = '0;
      ram_we_b   = 1'b0;
      gnt        = '0;
      for (int i = 0; i < NCORE; i++) begin
         core_port[i] = PORT_NONE;
         if (vld_a && idx_a == core_idx_t'(i)) begin
            ram_addr_a   = addr[i*AW +: AW];
            ram_data_a   = wdata[i*DW +: DW];
            ram_we_a     = we[i];
            core_port[i] = PORT_A;
         end
         if (vld_b && idx_b == core_idx_t'(i)) begin
            ram_addr_b   = addr[i*AW +: AW];
            ram_data_b   = wdata[i*DW +: DW];
            ram_we_b     = we[i];
            core_port[i] = PORT_B;
         end
         gnt[i] = (core_port[i] != PORT_NONE);
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (vld_a) rr_ptr_d = idx_inc(vld_b ? idx_b : idx_a, NCORE);
      rd_a_d  = vld_a && !ram_we_a;
      rd_b_d  = vld_b && !ram_we_b;
      fwd_a_d = rd_a_d && ram_we_b && (ram_addr_a == ram_addr_b);
      fwd_b_d = rd_b_d && ram_we_a && (ram_addr_a == ram_addr_b);
      cnt_d   = cnt_q;
      if (conflict && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q     <= '0;
         rd_a_q       <= 1'b0;
         rd_b_q       <= 1'b0;
         own_a_q      <= '0;
         own_b_q      <= '0;
         fwd_a_q      <= 1'b0;
         fwd_b_q      <= 1'b0;
         fwd_data_a_q <= '0;
         fwd_data_b_q <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < NCORE; i++) hold_q[i] <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         rd_a_q       <= rd_a_d;
         rd_b_q       <= rd_b_d;
         own_a_q      <= idx_a;
         own_b_q      <= idx_b;
         fwd_a_q      <= fwd_a_d;
         fwd_b_q      <= fwd_b_d;
         fwd_data_a_q <= ram_data_b;
         fwd_data_b_q <= ram_data_a;
         cnt_q        <= cnt_d;
         for (int i = 0; i < NCORE; i++) hold_q[i] <= rdata_lane[i];
      end
   end

   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int i = 0; i < NCORE; i++) begin
         rdata_lane[i] = hold_q[i];
         if (rd_a_q && own_a_q == core_idx_t'(i)) begin
            rvalid[i]     = 1'b1;
            rdata_lane[i] = fwd_a_q ? fwd_data_a_q : ram_q_a;
         end
         if (rd_b_q && own_b_q == core_idx_t'(i)) begin
            rvalid[i]     = 1'b1;
            rdata_lane[i] = fwd_b_q ? fwd_data_b_q : ram_q_b;
         end
         rdata[i*DW +: DW] = rdata_lane[i];
      end
   end

   assign conflict_cnt = cnt_q;

endmodule
